// File: rtl/nioslab2_pio_led_out.sv
// Avalon-MM LED output PIO with atomic set/clear; the blink engine (MASK/PERIOD/STATUS) is built only with PIO_OUT_BLINK_EN.
// Latency: writes reach out_port and readdata is valid 1 clk after the access; there is no waitrequest, so every cycle is accepted.
module nioslab2_pio_led_out #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PRESCALE    = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_MASK   = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_SET    = 3'd4;
  localparam logic [2:0] A_CLR    = 3'd5;

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [31:0]      rd_q, rd_d;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_d = data_q;
    if (wr) begin
      case (address)
        A_DATA:  data_d = wd;
        A_SET:   data_d = data_q | wd;
        A_CLR:   data_d = data_q & ~wd;
        default: data_d = data_q;
      endcase
    end
  end

`ifdef PIO_OUT_BLINK_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [15:0]      hcnt_q, hcnt_d;
  logic [15:0]      period_q, period_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             phase_q, phase_d;
  logic             tick;

  assign tick = (pcnt_q == PW'(PRESCALE - 1));

  always_comb begin
    pcnt_d   = tick ? '0 : pcnt_q + 1'b1;
    mask_d   = (wr && address == A_MASK) ? wd : mask_q;
    period_d = period_q;
    hcnt_d   = hcnt_q;
    phase_d  = phase_q;
    // A PERIOD write restarts the half-period from phase 0, overriding any tick on the same edge.
    if (wr && address == A_PERIOD) begin
      period_d = writedata[15:0];
      hcnt_d   = '0;
      phase_d  = 1'b0;
    end else if (period_q == 16'd0) begin
      hcnt_d  = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      if (hcnt_q == period_q - 16'd1) begin
        hcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        hcnt_d = hcnt_q + 16'd1;
      end
    end
    out_d = data_d ^ (mask_q & {WIDTH{phase_d}});
  end

  always_comb begin
    case (address)
      A_DATA:   rd_d = 32'(data_q);
      A_MASK:   rd_d = 32'(mask_q);
      A_PERIOD: rd_d = 32'(period_q);
      A_STATUS: rd_d = 32'(phase_q);
      default:  rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      mask_q   <= '0;
      phase_q  <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      mask_q   <= mask_d;
      phase_q  <= phase_d;
    end
  end
`else
  always_comb begin
    out_d = data_d;
    rd_d  = (address == A_DATA) ? 32'(data_q) : '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VALUE;
      out_q  <= RESET_VALUE;
      rd_q   <= '0;
    end else begin
      data_q <= data_d;
      out_q  <= out_d;
      rd_q   <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign out_port = out_q;

endmodule

// File: tb/tb_nioslab2_pio_led_out.sv
// Bench for nioslab2_pio_led_out: directed sequences plus random accesses checked against a tick-counting model.
module tb_nioslab2_pio_led_out;

  localparam int         W        = 4;
  localparam logic [3:0] RV       = 4'h6;
  localparam int         PRESCALE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  int vectors     = 0;
  int miscompares = 0;

  // Model: register contents plus elapsed edges/ticks; phase derives from tick count.
  logic [3:0]  m_data;
  logic [3:0]  m_mask;
  logic [15:0] m_period;
  int          edge_cnt;
  int          ticks;

  nioslab2_pio_led_out #(
    .WIDTH(W), .RESET_VALUE(RV), .PRESCALE(PRESCALE)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  function automatic logic m_phase();
    if (m_period == 16'd0) return 1'b0;
    return ((ticks / int'(m_period)) % 2) == 1;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_data);
`ifdef PIO_OUT_BLINK_EN
      3'd1: return 32'(m_mask);
      3'd2: return 32'(m_period);
      3'd3: return 32'(m_phase());
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] d);
    logic [31:0] exp_rd;
    logic [3:0]  old_mask;
    logic        wr;
    bit          tick;
    bit          pwrite;
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = d;
    exp_rd     = m_read(a);
    wr         = cs & ~wn;
    @(posedge clk);
    tick     = (edge_cnt % PRESCALE) == PRESCALE - 1;
    edge_cnt++;
    old_mask = m_mask;
    pwrite   = 1'b0;
    if (wr) begin
      case (a)
        3'd0: m_data = d[3:0];
        3'd4: m_data = m_data | d[3:0];
        3'd5: m_data = m_data & ~d[3:0];
`ifdef PIO_OUT_BLINK_EN
        3'd1: m_mask = d[3:0];
        3'd2: begin m_period = d[15:0]; pwrite = 1'b1; end
`endif
        default: ;
      endcase
    end
    if (pwrite) ticks = 0;
    else if (tick) ticks++;
    #1;
    check("out_port", 32'(out_port), 32'(m_data ^ (old_mask & {4{m_phase()}})));
    check("readdata", readdata, exp_rd);
  endtask

  // Reset is held for n edges while a DATA write is attempted; that write must be dropped.
  task automatic do_reset(input int n);
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = 32'hFFFF_FFF9;
    repeat (n) @(posedge clk);
    #1;
    m_data = RV; m_mask = '0; m_period = '0; edge_cnt = 0; ticks = 0;
    check("rst_out_port", 32'(out_port), 32'(RV));
    check("rst_readdata", readdata, 32'd0);
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'd3, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic run_to_phase1();
    for (int i = 0; i < 40 && !m_phase(); i++) idle(1);
  endtask

  initial begin
    logic [2:0]  ra;
    logic [31:0] rd;
    do_reset(3);
    step(3'd0, 1'b0, 1'b1, 32'd0);
    check("read_reset_value", readdata, 32'(RV));

    step(3'd0, 1'b1, 1'b0, 32'h0000_000A);
    check("data_write", 32'(out_port), 32'hA);
    step(3'd4, 1'b1, 1'b0, 32'h0000_0001);
    check("outset", 32'(out_port), 32'hB);
    step(3'd5, 1'b1, 1'b0, 32'h0000_0008);
    check("outclr", 32'(out_port), 32'h3);
    step(3'd0, 1'b1, 1'b1, 32'd0);
    check("read_data", readdata, 32'h3);
    step(3'd0, 1'b0, 1'b0, 32'h0000_000F);
    check("cs_low_ignored", 32'(out_port), 32'h3);
    step(3'd1, 1'b1, 1'b0, 32'h0000_000F);
    step(3'd1, 1'b1, 1'b1, 32'd0);
    step(3'd4, 1'b1, 1'b1, 32'd0);
    step(3'd6, 1'b1, 1'b0, 32'hFFFF_FFFF);
    step(3'd7, 1'b1, 1'b1, 32'd0);
`ifndef PIO_OUT_BLINK_EN
    check("mask_absent", readdata, 32'd0);
`endif

`ifdef PIO_OUT_BLINK_EN
    step(3'd0, 1'b1, 1'b0, 32'h0);
    step(3'd1, 1'b1, 1'b0, 32'h5);
    step(3'd2, 1'b1, 1'b0, 32'h3);
    idle(30);
    run_to_phase1();
    check("phase1_pins", 32'(out_port), 32'h5);
    step(3'd2, 1'b1, 1'b0, 32'h0);
    check("freeze_pins", 32'(out_port), 32'h0);
    idle(100);
    step(3'd2, 1'b1, 1'b0, 32'h3);
    run_to_phase1();
    do_reset(2);
    step(3'd1, 1'b1, 1'b0, 32'h5);
    idle(20);
    check("no_resume", 32'(out_port), 32'(RV));
`endif

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset($urandom_range(1, 3));
      ra = 3'($urandom_range(0, 7));
      rd = (ra == 3'd2) ? 32'($urandom_range(0, 3)) : $urandom;
      step(ra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
